// File: rtl/qam_pkg.sv
// rtl/qam_pkg.sv - shared constants and FSM encoding for the QAM symbol scheduler
package qam_pkg;

  localparam int BITS_PER_SYM_DEF = 4;
  localparam int IQ_W_DEF         = BITS_PER_SYM_DEF / 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } sched_state_t;

endpackage

// File: rtl/qam_symbol_sched_if.sv
// rtl/qam_symbol_sched_if.sv - bit-source request and I/Q symbol handshake bundle
interface qam_symbol_sched_if import qam_pkg::*; #(
  parameter int BITS_PER_SYM = BITS_PER_SYM_DEF
);

  localparam int IQ_W = BITS_PER_SYM / 2;

  logic            bit_req;
  logic            bit_in;
  logic            bit_valid;
  logic [IQ_W-1:0] sym_i;
  logic [IQ_W-1:0] sym_q;
  logic            sym_valid;
  logic            sym_ready;

  // master is the scheduler; slave is the source/modulator side
  modport master (
    output bit_req, sym_i, sym_q, sym_valid,
    input  bit_in, bit_valid, sym_ready
  );

  modport slave (
    input  bit_req, sym_i, sym_q, sym_valid,
    output bit_in, bit_valid, sym_ready
  );

endinterface

// File: rtl/qam_sym_fifo2.sv
// rtl/qam_sym_fifo2.sv - two-entry symbol FIFO, push+pop legal when full
module qam_sym_fifo2 import qam_pkg::*; #(
  parameter int W = BITS_PER_SYM_DEF
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic         o_full,
  output logic         o_empty
);

  logic [W-1:0] r_head;
  logic [W-1:0] r_tail;
  logic [1:0]   r_cnt;
  logic         w_pop;
  logic         w_push;

  // a pop on an empty FIFO is ignored, so push+pop when empty is a plain push
  assign w_pop  = i_pop && (r_cnt != 2'd0);
  assign w_push = i_push && ((r_cnt != 2'd2) || w_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_head <= i_data;
          else               r_tail <= i_data;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_head <= r_tail;
          r_cnt  <= r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_head <= i_data;
          end else begin
            r_head <= r_tail;
            r_tail <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_head  = r_head;
  assign o_full  = r_cnt[1];
  assign o_empty = (r_cnt == 2'd0);

endmodule

// File: rtl/qam_symbol_sched.sv
// rtl/qam_symbol_sched.sv - paces bit requests, assembles I/Q symbols, buffers them for the mapper
module qam_symbol_sched import qam_pkg::*; #(
  parameter int BITS_PER_SYM = BITS_PER_SYM_DEF,
  parameter int DIV_W        = 10,
  parameter int CNT_W        = 16
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_enable,
  input  logic [DIV_W-1:0]    i_bit_period,
  qam_symbol_sched_if.master  bus,
  output logic                o_overrun,
  output logic [CNT_W-1:0]    o_sym_count,
  output logic                o_busy
);

  localparam int IQ_W   = BITS_PER_SYM / 2;
  localparam int ACNT_W = $clog2(BITS_PER_SYM);
  localparam logic [ACNT_W-1:0] LAST_BIT = ACNT_W'(BITS_PER_SYM - 1);

  sched_state_t            r_state;
  logic [DIV_W-1:0]        r_timer;
  logic [BITS_PER_SYM-2:0] r_asm;
  logic [ACNT_W-1:0]       r_asm_cnt;
  logic                    r_overrun;
  logic [CNT_W-1:0]        r_sym_count;

  logic                    w_full;
  logic                    w_empty;
  logic                    w_valid;
  logic                    w_pop;
  logic                    w_bit_req;
  logic                    w_drain_done;
  logic                    w_asm_flush;
  logic                    w_bit_take;
  logic                    w_sym_done;
  logic                    w_drop;
  logic [BITS_PER_SYM-1:0] w_asm_next;
  logic [BITS_PER_SYM-1:0] w_head;

  assign w_valid   = !w_empty;
  assign w_pop     = w_valid && bus.sym_ready;
  assign w_bit_req = (r_state == RUN) && (r_timer == '0) && !w_full;

  // stay in DRAIN one more cycle if a bit arriving now would still complete a symbol
  assign w_drain_done = (r_state == DRAIN) && w_empty &&
                        !(bus.bit_valid && (r_asm_cnt == LAST_BIT));
  assign w_asm_flush  = ((r_state == RUN) && !i_enable) || w_drain_done;
  assign w_bit_take   = bus.bit_valid &&
                        (((r_state == RUN) && i_enable) ||
                         ((r_state == DRAIN) && !w_drain_done));
  assign w_sym_done   = w_bit_take && (r_asm_cnt == LAST_BIT);
  assign w_drop       = w_sym_done && w_full && !w_pop;
  assign w_asm_next   = {r_asm, bus.bit_in};

  qam_sym_fifo2 #(.W(BITS_PER_SYM)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_sym_done),
    .i_data  (w_asm_next),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_timer     <= '0;
      r_asm       <= '0;
      r_asm_cnt   <= '0;
      r_overrun   <= 1'b0;
      r_sym_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_enable) begin
            r_state <= RUN;
            r_timer <= '0;
          end
        end
        RUN: begin
          if (!i_enable) begin
            r_state <= DRAIN;
            r_timer <= '0;
          end else if (w_bit_req) begin
            r_timer <= i_bit_period;
          end else if (r_timer != '0) begin
            r_timer <= r_timer - DIV_W'(1);
          end
        end
        DRAIN: begin
          if (w_drain_done) begin
            r_state <= i_enable ? RUN : IDLE;
            r_timer <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_asm_flush) begin
        r_asm_cnt <= '0;
      end else if (w_bit_take) begin
        r_asm     <= w_asm_next[BITS_PER_SYM-2:0];
        r_asm_cnt <= w_sym_done ? '0 : r_asm_cnt + ACNT_W'(1);
      end

      if (w_drop) r_overrun <= 1'b1;
      if (w_pop)  r_sym_count <= r_sym_count + CNT_W'(1);
    end
  end

  assign bus.bit_req   = w_bit_req;
  assign bus.sym_valid = w_valid;
  assign bus.sym_i     = w_head[BITS_PER_SYM-1:IQ_W];
  assign bus.sym_q     = w_head[IQ_W-1:0];
  assign o_overrun     = r_overrun;
  assign o_sym_count   = r_sym_count;
  assign o_busy        = (r_state != IDLE);

endmodule

// File: tb/tb_qam_symbol_sched.sv
// tb/tb_qam_symbol_sched.sv - randomized self-checking bench for qam_symbol_sched
module tb_qam_symbol_sched;

  localparam int BPS   = 4;
  localparam int DIV_W = 10;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b0;
  logic [DIV_W-1:0] bit_period = '0;
  logic             overrun;
  logic             busy;
  logic [CNT_W-1:0] sym_count;

  qam_symbol_sched_if #(.BITS_PER_SYM(BPS)) sif ();

  qam_symbol_sched #(.BITS_PER_SYM(BPS), .DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_enable     (enable),
    .i_bit_period (bit_period),
    .bus          (sif),
    .o_overrun    (overrun),
    .o_sym_count  (sym_count),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model: bits collected in arrival order, symbols in a 2-deep queue
  logic [BPS-1:0] exp_syms[$];
  bit             part[$];
  bit             src_bits[$];
  int unsigned    exp_cnt;
  bit             exp_ovr;
  bit             auto_ans;
  bit             pend;
  bit             force_bv;

  task automatic clear_model();
    exp_syms.delete();
    part.delete();
    src_bits.delete();
    exp_cnt  = 0;
    exp_ovr  = 1'b0;
    auto_ans = 1'b0;
    pend     = 1'b0;
    force_bv = 1'b0;
  endtask

  // one clock of activity: drive source bit, check head, update model, advance
  task automatic step();
    logic           b;
    logic [BPS-1:0] s;
    logic [BPS-1:0] h;
    b = 1'b0;
    sif.bit_valid = pend | force_bv;
    if (sif.bit_valid)
      b = (src_bits.size() != 0) ? src_bits.pop_front() : 1'($urandom_range(0, 1));
    sif.bit_in = b;
    force_bv = 1'b0;
    pend = auto_ans & sif.bit_req;

    total++;
    if (sif.sym_valid !== (exp_syms.size() != 0)) begin
      bad++;
      $display("FAIL sym_valid: got %b want %b", sif.sym_valid, exp_syms.size() != 0);
    end
    if (sif.sym_valid === 1'b1 && exp_syms.size() != 0) begin
      h = exp_syms[0];
      total++;
      if ({sif.sym_i, sif.sym_q} !== h) begin
        bad++;
        $display("FAIL head_symbol: got I=%b Q=%b want I=%b Q=%b",
                 sif.sym_i, sif.sym_q, h[BPS-1:BPS/2], h[BPS/2-1:0]);
      end
      if (sif.sym_ready === 1'b1) begin
        void'(exp_syms.pop_front());
        exp_cnt++;
      end
    end
    if (sif.bit_valid) begin
      part.push_back(b);
      if (part.size() == BPS) begin
        s = '0;
        foreach (part[i]) s[BPS-1-i] = part[i];
        part.delete();
        if (exp_syms.size() < 2) exp_syms.push_back(s);
        else                     exp_ovr = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    bit_period = '0;
    sif.sym_ready = 1'b0;
    sif.bit_valid = 1'b0;
    sif.bit_in = 1'b0;
    clear_model();
    repeat (3) @(posedge clk);
    #3;
    total++;
    if ({sif.bit_req, sif.sym_valid, sif.sym_i, sif.sym_q, overrun, busy} !== '0 || sym_count !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got req=%b v=%b i=%b q=%b ovr=%b busy=%b cnt=%0d want all 0",
               sif.bit_req, sif.sym_valid, sif.sym_i, sif.sym_q, overrun, busy, sym_count);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || sif.bit_req !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: got busy=%b req=%b want 0 0", busy, sif.bit_req);
    end
  endtask

  task automatic test_pacing();
    bit exp_r;
    bit_period = 3;
    sif.sym_ready = 1'b1;
    enable = 1'b1;
    auto_ans = 1'b1;
    src_bits = '{1, 0, 1, 1, 0, 0, 1, 0};
    for (int k = 0; k < 32; k++) begin
      exp_r = (k >= 1) && ((k - 1) % 4 == 0);
      total++;
      if (sif.bit_req !== exp_r) begin
        bad++;
        $display("FAIL pacing_req k=%0d: got %b want %b", k, sif.bit_req, exp_r);
      end
      if (k == 14) begin
        total++;
        if (sif.sym_valid !== 1'b0) begin
          bad++;
          $display("FAIL latency_early: got sym_valid=%b want 0", sif.sym_valid);
        end
      end
      if (k == 15 || k == 31) begin
        total++;
        if (sif.sym_valid !== 1'b1 || {sif.sym_i, sif.sym_q} !== ((k == 15) ? 4'b1011 : 4'b0010)) begin
          bad++;
          $display("FAIL pacing_symbol k=%0d: got v=%b I=%b Q=%b want v=1 %b",
                   k, sif.sym_valid, sif.sym_i, sif.sym_q, (k == 15) ? 4'b1011 : 4'b0010);
        end
      end
      step();
    end
    auto_ans = 1'b0;
    total++;
    if (sym_count !== CNT_W'(2)) begin
      bad++;
      $display("FAIL pacing_count: got %0d want 2", sym_count);
    end
  endtask

  task automatic test_back_pressure();
    int n;
    bit seen;
    sif.sym_ready = 1'b0;
    bit_period = '0;
    auto_ans = 1'b1;
    repeat (30) step();
    total++;
    if (sif.bit_req !== 1'b0) begin
      bad++;
      $display("FAIL throttle_req: got %b want 0", sif.bit_req);
    end
    total++;
    if (overrun !== 1'b0) begin
      bad++;
      $display("FAIL throttle_overrun: got %b want 0", overrun);
    end
    // full FIFO: completing bit coincides with a pop
    auto_ans = 1'b0;
    step();
    n = BPS - part.size();
    for (int j = 0; j < n; j++) begin
      force_bv = 1'b1;
      sif.sym_ready = (j == n - 1);
      step();
    end
    sif.sym_ready = 1'b0;
    total++;
    if (overrun !== 1'b0 || sif.bit_req !== 1'b0) begin
      bad++;
      $display("FAIL full_push_pop: got ovr=%b req=%b want ovr=0 req=0", overrun, sif.bit_req);
    end
    step();
    sif.sym_ready = 1'b1;
    auto_ans = 1'b1;
    seen = 1'b0;
    for (int j = 0; j < 8; j++) begin
      if (sif.bit_req === 1'b1) seen = 1'b1;
      step();
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL resume_req: got no bit_req want bit_req after release");
    end
  endtask

  task automatic test_overrun();
    sif.sym_ready = 1'b0;
    auto_ans = 1'b1;
    repeat (20) step();
    auto_ans = 1'b0;
    repeat (2) step();
    repeat (4) begin
      force_bv = 1'b1;
      step();
    end
    total++;
    if (overrun !== 1'b1) begin
      bad++;
      $display("FAIL overrun_set: got %b want 1", overrun);
    end
    repeat (5) step();
    total++;
    if (overrun !== 1'b1) begin
      bad++;
      $display("FAIL overrun_sticky: got %b want 1", overrun);
    end
    sif.sym_ready = 1'b1;
    repeat (4) step();
  endtask

  task automatic test_drain();
    bit done;
    test_reset();
    bit_period = 2;
    sif.sym_ready = 1'b0;
    enable = 1'b1;
    step();
    repeat (6) begin
      force_bv = 1'b1;
      step();
    end
    enable = 1'b0;
    part.delete();
    step();
    repeat (3) begin
      total++;
      if (sif.bit_req !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL drain_hold: got req=%b busy=%b want 0 1", sif.bit_req, busy);
      end
      step();
    end
    sif.sym_ready = 1'b1;
    done = 1'b0;
    for (int j = 0; j < 10 && !done; j++) begin
      step();
      if (busy === 1'b0) done = 1'b1;
    end
    total++;
    if (!done || sym_count !== CNT_W'(1)) begin
      bad++;
      $display("FAIL drain_idle: got busy=%b cnt=%0d want busy=0 cnt=1", busy, sym_count);
    end
    enable = 1'b1;
    step();
    repeat (BPS) begin
      force_bv = 1'b1;
      step();
    end
    repeat (3) step();
    total++;
    if (sym_count !== CNT_W'(2)) begin
      bad++;
      $display("FAIL reenable_symbol: got cnt=%0d want 2", sym_count);
    end
  endtask

  task automatic test_async_reset();
    enable = 1'b1;
    bit_period = 1;
    sif.sym_ready = 1'b0;
    auto_ans = 1'b1;
    repeat (12) step();
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if ({sif.bit_req, sif.sym_valid, sif.sym_i, sif.sym_q, overrun, busy} !== '0 || sym_count !== '0) begin
      bad++;
      $display("FAIL async_reset: got req=%b v=%b i=%b q=%b ovr=%b busy=%b cnt=%0d want all 0",
               sif.bit_req, sif.sym_valid, sif.sym_i, sif.sym_q, overrun, busy, sym_count);
    end
    clear_model();
    sif.bit_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (sif.bit_req !== 1'b1 || busy !== 1'b1 || sif.sym_valid !== 1'b0) begin
      bad++;
      $display("FAIL first_req_after_reset: got req=%b busy=%b v=%b want 1 1 0",
               sif.bit_req, busy, sif.sym_valid);
    end
  endtask

  task automatic test_random();
    bit done;
    for (int k = 0; k < 400; k++) begin
      if (k % 50 == 0) bit_period = DIV_W'($urandom_range(0, 3));
      sif.sym_ready = ($urandom_range(0, 3) != 0);
      auto_ans = 1'b1;
      step();
    end
    auto_ans = 1'b0;
    repeat (2) step();
    enable = 1'b0;
    part.delete();
    sif.sym_ready = 1'b1;
    step();
    done = 1'b0;
    for (int j = 0; j < 20 && !done; j++) begin
      step();
      if (busy === 1'b0) done = 1'b1;
    end
    total++;
    if (!done || sym_count !== CNT_W'(exp_cnt) || overrun !== exp_ovr) begin
      bad++;
      $display("FAIL random_final: got busy=%b cnt=%0d ovr=%b want busy=0 cnt=%0d ovr=%b",
               busy, sym_count, overrun, CNT_W'(exp_cnt), exp_ovr);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_pacing();
    test_back_pressure();
    test_overrun();
    test_drain();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
